// File: rtl/fifo_wr_arbiter_if.sv
// Write-port bundle between NUM_REQ producers, the arbiter and sync_fifo.
// The master modport is the arbiter's view; slave is the producer/FIFO side.
interface fifo_wr_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 16
);
    localparam int unsigned OwnerW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] data;
    logic [NUM_REQ-1:0]        gnt;
    logic [OwnerW-1:0]         owner;
    logic                      locked;
    logic                      fifo_full;
    logic                      fifo_wr_en;
    logic [DATA_W-1:0]         fifo_din;

    modport master (
        input  req, data, fifo_full,
        output gnt, owner, locked, fifo_wr_en, fifo_din
    );

    modport slave (
        output req, data, fifo_full,
        input  gnt, owner, locked, fifo_wr_en, fifo_din
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter for sync_fifo with burst locking of up to MAX_BURST beats.
// gnt/fifo_wr_en/fifo_din are combinational so fifo_full backpressure has zero latency.
// Optional: define FIFO_ARB_STATS_EN to add per-requester saturating accepted-beat counters.
module fifo_wr_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
`ifdef FIFO_ARB_STATS_EN
    input  logic                  stats_clr,
    output logic [NUM_REQ*16-1:0] beat_stats,
`endif
    fifo_wr_arbiter_if.master     bus
);
    localparam int unsigned PtrW = $clog2(NUM_REQ);
    localparam int unsigned CntW = $clog2(MAX_BURST + 1);

    typedef enum logic [0:0] {StIdle, StLock} state_e;

    state_e              state_q;
    logic [PtrW-1:0]     owner_q;
    logic [PtrW-1:0]     rr_ptr_q;
    logic [CntW-1:0]     beat_cnt_q;

    logic                arb_mode;
    logic [PtrW-1:0]     base;
    logic                win_found;
    logic [PtrW-1:0]     win_idx;
    logic [PtrW-1:0]     sel_idx;
    logic [NUM_REQ-1:0]  gnt;
    logic                accept;
    int                  srch;

    function automatic logic [PtrW-1:0] inc_wrap(logic [PtrW-1:0] v);
        return (32'(v) == NUM_REQ - 1) ? '0 : v + PtrW'(1);
    endfunction

    // A locked owner that drops its request is arbitrated away in the same cycle.
    assign arb_mode = (state_q == StIdle) || !bus.req[owner_q];
    assign base     = (state_q == StIdle) ? rr_ptr_q : inc_wrap(owner_q);

    // Round-robin search starting at base, wrapping NUM_REQ-1 -> 0.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        srch      = 0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            srch = (int'(base) + k) % int'(NUM_REQ);
            if (!win_found && bus.req[srch]) begin
                win_found = 1'b1;
                win_idx   = PtrW'(srch);
            end
        end
    end

    // One-hot grant, gated by reset and fifo_full.
    always_comb begin
        gnt = '0;
        if (rstn && !bus.fifo_full) begin
            if (arb_mode) begin
                if (win_found) gnt[win_idx] = 1'b1;
            end else begin
                gnt[owner_q] = 1'b1;
            end
        end
    end

    assign sel_idx        = arb_mode ? win_idx : owner_q;
    assign accept         = |(bus.req & gnt);
    assign bus.gnt        = gnt;
    assign bus.fifo_wr_en = accept;
    assign bus.fifo_din   = accept ? bus.data[int'(sel_idx)*DATA_W +: DATA_W] : '0;
    assign bus.owner      = owner_q;
    assign bus.locked     = (state_q == StLock);

    // Arbitration FSM: owner, round-robin pointer and burst beat count.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= StIdle;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else if (accept) begin
            if (arb_mode) begin
                owner_q    <= win_idx;
                beat_cnt_q <= CntW'(1);
                if (MAX_BURST > 1) begin
                    state_q <= StLock;
                    // Handover from a dropped owner moves the pointer past it.
                    if (state_q == StLock) rr_ptr_q <= inc_wrap(owner_q);
                end else begin
                    rr_ptr_q <= inc_wrap(win_idx);
                end
            end else begin
                beat_cnt_q <= beat_cnt_q + CntW'(1);
                if (beat_cnt_q == CntW'(MAX_BURST - 1)) begin
                    state_q  <= StIdle;
                    rr_ptr_q <= inc_wrap(owner_q);
                end
            end
        end else if (state_q == StLock && !bus.req[owner_q]) begin
            // Owner gone and nobody else accepted: release the lock.
            state_q  <= StIdle;
            rr_ptr_q <= inc_wrap(owner_q);
        end
    end

`ifdef FIFO_ARB_STATS_EN
    logic [NUM_REQ-1:0][15:0] stats_q;

    // Saturating accepted-beat counters; clear beats a same-cycle increment.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stats_q <= '0;
        end else if (stats_clr) begin
            stats_q <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                if (bus.req[i] && gnt[i] && stats_q[i] != 16'hFFFF) begin
                    stats_q[i] <= stats_q[i] + 16'd1;
                end
            end
        end
    end

    assign beat_stats = stats_q;
`endif
endmodule
